// File: rtl/tt_um_lif_neuron.sv
// tt_um_lif_neuron
// Single leaky integrate-and-fire neuron with an adaptive threshold,
// packaged as a Tiny Tapeout user macro.
//
// Each enabled clock the 8-bit input current is added to the 8-bit membrane
// potential V after a shift-based leak. When the result reaches the effective
// threshold, the neuron does the following:
//   - emits a registered one-cycle spike,
//   - clears V,
//   - enters a refractory period,
//   - raises the adaptive threshold term.
//
// Ports:
//   clk      system clock, all state updates on the rising edge
//   rst      synchronous active-low reset
//   ena      design enable; 0 freezes the neuron state (config still writable)
//   ui_in    input current I (unsigned)
//   uo_out   [7] spike pulse, [6:0] V[7:1]
//   uio_in   config port: [7] write strobe, [6:5] select, [4:0] data
//              select 00 thresh_code, 01 leak_shift (data[2:0]),
//              select 10 refract,     11 adapt_inc
//   uio_out  tied to 0
//   uio_oe   tied to 0 (all bidirectional pins are inputs)
module tt_um_lif_neuron #(
  parameter int DEF_THRESH_CODE = 25,
  parameter int DEF_LEAK_SHIFT  = 3,
  parameter int DEF_REFRACT     = 4,
  parameter int DEF_ADAPT_INC   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [4:0] RST_THRESH_CODE = DEF_THRESH_CODE[4:0];
  localparam logic [2:0] RST_LEAK_SHIFT  = DEF_LEAK_SHIFT[2:0];
  localparam logic [4:0] RST_REFRACT     = DEF_REFRACT[4:0];
  localparam logic [4:0] RST_ADAPT_INC   = DEF_ADAPT_INC[4:0];

  // Configuration registers
  logic [4:0] thresh_code;
  logic [2:0] leak_shift;
  logic [4:0] refract;
  logic [4:0] adapt_inc;

  // Neuron state
  logic [7:0] v;
  logic [7:0] adapt;
  logic [4:0] refract_cnt;
  logic       spike;

  // Datapath
  logic [7:0] leak;
  logic [9:0] sum_wide;
  logic [7:0] sum_sat;
  logic [8:0] theta_wide;
  logic [7:0] theta;
  logic [8:0] adapt_up_wide;
  logic [7:0] adapt_up;
  logic [7:0] adapt_dec;
  logic       fire;

  always_comb begin
    leak = '0;
    if (leak_shift != 3'd0) begin
      leak = v >> leak_shift;
    end

    // leak <= v, so the subtraction never underflows; only the add can
    // exceed 8 bits.
    sum_wide = {2'b00, v} - {2'b00, leak} + {2'b00, ui_in};
    sum_sat  = (sum_wide > 10'd255) ? 8'hFF : sum_wide[7:0];

    theta_wide = {1'b0, thresh_code, 3'b000} + {1'b0, adapt};
    theta      = theta_wide[8] ? 8'hFF : theta_wide[7:0];

    adapt_up_wide = {1'b0, adapt} + {4'b0000, adapt_inc};
    adapt_up      = adapt_up_wide[8] ? 8'hFF : adapt_up_wide[7:0];

    adapt_dec = (adapt != 8'd0) ? (adapt - 8'd1) : 8'd0;

    fire = (sum_sat >= theta);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      thresh_code <= RST_THRESH_CODE;
      leak_shift  <= RST_LEAK_SHIFT;
      refract     <= RST_REFRACT;
      adapt_inc   <= RST_ADAPT_INC;
      v           <= '0;
      adapt       <= '0;
      refract_cnt <= '0;
      spike       <= 1'b0;
    end else begin
      // Config writes ignore ena. The new value takes effect on the next
      // cycle because the datapath reads the registered copy.
      if (uio_in[7]) begin
        case (uio_in[6:5])
          2'b00:   thresh_code <= uio_in[4:0];
          2'b01:   leak_shift  <= uio_in[2:0];
          2'b10:   refract     <= uio_in[4:0];
          default: adapt_inc   <= uio_in[4:0];
        endcase
      end

      if (ena) begin
        if (refract_cnt != 5'd0) begin
          v           <= '0;
          refract_cnt <= refract_cnt - 5'd1;
          spike       <= 1'b0;
          adapt       <= adapt_dec;
        end else if (fire) begin
          // The adapt term steps up without decaying on the spike cycle.
          v           <= '0;
          refract_cnt <= refract;
          spike       <= 1'b1;
          adapt       <= adapt_up;
        end else begin
          v     <= sum_sat;
          spike <= 1'b0;
          adapt <= adapt_dec;
        end
      end
    end
  end

  assign uo_out  = {spike, v[7:1]};
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_lif_neuron.sv
module tb_tt_um_lif_neuron;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'hFF;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  always #5 clk = ~clk;

  tt_um_lif_neuron dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  int vectors = 0;
  int miscompares = 0;

  // ---------------- driver tasks ----------------
  // Advance one rising edge and settle 1 ns past it. Inputs are changed at
  // this point, well clear of the next active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] observed,
                     input logic [7:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, observed, expected);
    end
  endtask

  task automatic step_chk(input string tag, input logic [7:0] expected);
    step();
    chk(tag, uo_out, expected);
  endtask

  task automatic cfg_write(input logic [7:0] word);
    uio_in = word;
    step();
    uio_in = 8'h00;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    // Reset held two edges with a full-scale input current
    step();
    step();
    chk("rst_uo", uo_out, 8'h00);
    chk("rst_uio_out", uio_out, 8'h00);
    chk("rst_uio_oe", uio_oe, 8'h00);

    rst   = 1'b1;
    ui_in = 8'h00;
    for (int i = 0; i < 10; i++) step();
    chk("idle_after_reset", uo_out, 8'h00);

    // Integration with defaults: theta 200, leak >>3, refract 4, inc 16
    ui_in = 8'd50;
    step_chk("int_v50", 8'd25);
    step_chk("int_v94", 8'd47);
    step_chk("int_v133", 8'd66);

    // ena low freezes V at 133
    ena = 1'b0;
    for (int i = 0; i < 5; i++) step_chk("ena_hold", 8'd66);
    ena = 1'b1;
    step_chk("int_v167", 8'd83);
    step_chk("int_v197", 8'd98);
    step_chk("spike1", 8'h80);          // 223 >= 200, adapt=16

    // Refractory: four cycles of V=0, adapt 16 -> 12
    for (int i = 0; i < 4; i++) step_chk("refract_v0", 8'h00);

    // Resume against the raised threshold
    step_chk("post_v50", 8'd25);        // theta 212
    step_chk("post_v94", 8'd47);        // theta 211
    step_chk("post_v133", 8'd66);       // theta 210
    step_chk("post_v167", 8'd83);       // theta 209
    step_chk("adapt_blocks", 8'd98);    // 197 < 208 with adapt=8
    step_chk("spike2", 8'h80);          // 223 >= 207

    // Config writes: threshold 40, leak off, refract 0 (written with ena=0)
    rst = 1'b0;
    step();
    chk("rst2_uo", uo_out, 8'h00);
    rst   = 1'b1;
    ena   = 1'b0;
    ui_in = 8'd20;
    cfg_write(8'h85);
    cfg_write(8'hA0);
    cfg_write(8'hC0);
    chk("cfg_frozen", uo_out, 8'h00);
    ena = 1'b1;
    step_chk("cfg_v20", 8'd10);
    step_chk("cfg_spike", 8'h80);       // 40 >= 40, adapt=16
    step_chk("cfg_reint_v20", 8'd10);   // no refractory, theta 56
    step_chk("cfg_v40", 8'd20);         // theta 55
    step_chk("cfg_spike2", 8'h80);      // 60 >= 54

    // Saturation: thresh 248, adapt_inc 31, leak off, refract 0, I=255
    rst = 1'b0;
    step();
    rst = 1'b1;
    ena = 1'b0;
    ui_in = 8'd255;
    cfg_write(8'h9F);
    cfg_write(8'hFF);
    cfg_write(8'hA0);
    cfg_write(8'hC0);
    ena = 1'b1;
    // adapt: 31, 62, ... 248, then capped at 255 from the 9th spike
    for (int i = 0; i < 12; i++) step_chk("sat_spike", 8'h80);

    // With thresh_code 0 and no input, theta equals adapt. A capped adapt of
    // 255 needs 255 decay cycles before theta reaches 0 and fires on I=0.
    ena   = 1'b0;
    ui_in = 8'd0;
    cfg_write(8'h80);
    step();
    ena = 1'b1;
    for (int i = 0; i < 255; i++) step_chk("adapt_cap_decay", 8'h00);
    step_chk("theta0_spike", 8'h80);
    step_chk("after_theta0", 8'h00);    // adapt back to 31

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
